// File: rtl/store_pkg.sv
// store_pkg: shared constants and types for the store unit.
//   - store type encodings (same 3-bit funct3 field as the load path)
//   - FSM state encoding
//   - byte lane width
//   - type_legal(): true for the three store types the unit supports
package store_pkg;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic type_legal(input logic [2:0] t);
    return (t == ST_SB) || (t == ST_SH) || (t == ST_SW);
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational byte-lane placement for a store.
// Ports:
//   i_off   [1:0]  byte offset within the word (addr[1:0])
//   i_type  [2:0]  store type (SB/SH/SW; anything else gives no enables)
//   i_data  [31:0] right-justified store data
//   o_be    [7:0]  enables over two words: [3:0] first word, [7:4] next word
//   o_data  [63:0] data shifted into its lanes across the two words
//   o_split        store spills into the next word
module store_lane_align (
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_type,
  input  logic [31:0] i_data,
  output logic [7:0]  o_be,
  output logic [63:0] o_data,
  output logic        o_split
);
  import store_pkg::*;

  logic [7:0] w_base;
  logic [5:0] w_shamt;

  always_comb begin
    w_base = 8'h00;
    case (i_type)
      ST_SB:   w_base = 8'h01;
      ST_SH:   w_base = 8'h03;
      ST_SW:   w_base = 8'h0F;
      default: w_base = 8'h00;
    endcase
  end

  assign w_shamt = 6'(i_off) * 6'(LANE_W);
  assign o_be    = w_base << i_off;
  // Bits outside the enabled lanes are left as-is; the byte enables mask them.
  assign o_data  = {32'h0, i_data} << w_shamt;
  assign o_split = |o_be[7:4];

endmodule

// File: rtl/store_unit.sv
// store_unit: single-outstanding store engine driving a word-addressed
// data memory with byte enables; word-crossing stores take two beats.
// Optional feature macro: STORE_MISALIGN_EN
//   defined   : word-crossing stores are split into BEAT0/BEAT1
//   undefined : word-crossing stores retire with err and no write
// Ports:
//   i_clk, i_rst (async, active high)
//   i_req_valid / o_req_ready, i_req_addr, i_req_data, i_req_type
//   o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, i_mem_ack
//   o_done, o_err (one-cycle retire pulses)
//
// state   | meaning
// S_IDLE  | ready for a request
// S_BEAT0 | first (or only) beat on the memory port, waiting for ack
// S_BEAT1 | second beat of a word-crossing store, waiting for ack
// S_RESP  | done/err pulse, request not accepted
module store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic [2:0]        i_req_type,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_done,
  output logic              o_err
);
  import store_pkg::*;

  state_t            r_state, w_state_nx;
  logic              r_mem_we, w_we_nx;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nx;
  logic [3:0]        r_mem_be, w_be_nx;
  logic [31:0]       r_mem_wdata, w_wdata_nx;
  logic              r_done, w_done_nx;
  logic              r_err, w_err_nx;

  logic [7:0]  w_be8;
  logic [63:0] w_data64;
  logic        w_split;
  logic        w_accept;
  logic        w_reject;

  store_lane_align u_align (
    .i_off   (i_req_addr[1:0]),
    .i_type  (i_req_type),
    .i_data  (i_req_data),
    .o_be    (w_be8),
    .o_data  (w_data64),
    .o_split (w_split)
  );

  assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef STORE_MISALIGN_EN
  logic [3:0]  r_be_hi;
  logic [31:0] r_data_hi;

  assign w_reject = !type_legal(i_req_type);

  // Second-beat lanes are captured at accept so later request changes are inert.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_be_hi   <= 4'h0;
      r_data_hi <= 32'h0;
    end else if (w_accept) begin
      r_be_hi   <= w_be8[7:4];
      r_data_hi <= w_data64[63:32];
    end
  end
`else
  logic w_unused_hi;

  assign w_reject    = !type_legal(i_req_type) || w_split;
  assign w_unused_hi = ^w_data64[63:32];
`endif

  always_comb begin
    w_state_nx = r_state;
    w_we_nx    = r_mem_we;
    w_addr_nx  = r_mem_addr;
    w_be_nx    = r_mem_be;
    w_wdata_nx = r_mem_wdata;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject) begin
            w_state_nx = S_RESP;
            w_done_nx  = 1'b1;
            w_err_nx   = 1'b1;
          end else begin
            w_state_nx = S_BEAT0;
            w_we_nx    = 1'b1;
            w_addr_nx  = {i_req_addr[ADDR_W-1:2], 2'b00};
            w_be_nx    = w_be8[3:0];
            w_wdata_nx = w_data64[31:0];
          end
        end
      end
      S_BEAT0: begin
        if (i_mem_ack) begin
`ifdef STORE_MISALIGN_EN
          if (|r_be_hi) begin
            w_state_nx = S_BEAT1;
            w_addr_nx  = r_mem_addr + ADDR_W'(4);
            w_be_nx    = r_be_hi;
            w_wdata_nx = r_data_hi;
          end else begin
            w_state_nx = S_RESP;
            w_we_nx    = 1'b0;
            w_done_nx  = 1'b1;
          end
`else
          w_state_nx = S_RESP;
          w_we_nx    = 1'b0;
          w_done_nx  = 1'b1;
`endif
        end
      end
`ifdef STORE_MISALIGN_EN
      S_BEAT1: begin
        if (i_mem_ack) begin
          w_state_nx = S_RESP;
          w_we_nx    = 1'b0;
          w_done_nx  = 1'b1;
        end
      end
`endif
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_we_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_mem_we    <= w_we_nx;
      r_mem_addr  <= w_addr_nx;
      r_mem_be    <= w_be_nx;
      r_mem_wdata <= w_wdata_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [2:0]  i_req_type;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic        o_done;
  logic        o_err;

  int n_tot = 0;
  int n_bad = 0;

  store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .i_req_type  (i_req_type),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    logic [3:0]  dly;
    logic        err;
    logic [1:0]  beats;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] typ, input logic [3:0] dly,
                              input logic err, input logic [1:0] beats,
                              input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                              input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1);
    vec_t v;
    v.addr = addr; v.data = data; v.typ = typ; v.dly = dly;
    v.err = err; v.beats = beats;
    v.a0 = a0; v.b0 = b0; v.w0 = w0;
    v.a1 = a1; v.b1 = b1; v.w1 = w1;
    return v;
  endfunction

  function automatic vec_t mk_err(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [2:0] typ);
    return mk(addr, data, typ, 4'd0, 1'b1, 2'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
  endfunction

  // Current time is a negedge; returns at the negedge after the ack was sampled.
  task automatic do_beat(input string tag, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] w, input int dly);
    chk({tag, "_we"}, 32'(o_mem_we), 32'd1);
    chk({tag, "_addr"}, o_mem_addr, a);
    chk({tag, "_be"}, 32'(o_mem_be), 32'(b));
    chk({tag, "_wdata"}, o_mem_wdata & lane_mask(b), w & lane_mask(b));
    for (int k = 0; k < dly; k++) begin
      @(negedge i_clk);
      chk({tag, "_hold_we"}, 32'(o_mem_we), 32'd1);
      chk({tag, "_hold_addr"}, o_mem_addr, a);
    end
    i_mem_ack = 1'b1;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_addr  = v.addr;
    i_req_data  = v.data;
    i_req_type  = v.typ;
    @(negedge i_clk);
    // scramble the request after accept; the captured copy must be used
    i_req_valid = 1'b0;
    i_req_addr  = ~v.addr;
    i_req_data  = ~v.data;
    i_req_type  = 3'b010;
    if (v.err) begin
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      chk({tag, "_err"}, 32'(o_err), 32'd1);
      chk({tag, "_nowe"}, 32'(o_mem_we), 32'd0);
      chk({tag, "_busy"}, 32'(o_req_ready), 32'd0);
    end else begin
      chk({tag, "_nodone0"}, 32'(o_done), 32'd0);
      do_beat({tag, "_b0"}, v.a0, v.b0, v.w0, int'(v.dly));
      if (v.beats == 2'd2) begin
        chk({tag, "_nodone1"}, 32'(o_done), 32'd0);
        do_beat({tag, "_b1"}, v.a1, v.b1, v.w1, int'(v.dly));
      end
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
      chk({tag, "_we_off"}, 32'(o_mem_we), 32'd0);
      chk({tag, "_busy"}, 32'(o_req_ready), 32'd0);
    end
    @(negedge i_clk);
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_ready_back"}, 32'(o_req_ready), 32'd1);
    chk({tag, "_we_idle"}, 32'(o_mem_we), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr = 32'h0;
    i_req_data = 32'h0;
    i_req_type = 3'b000;
    i_mem_ack = 1'b0;

    vecs[0]  = mk(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 4'd0, 1'b0, 2'd1,
                  32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0);
    vecs[1]  = mk(32'h0000_0203, 32'h0000_00A5, 3'b000, 4'd0, 1'b0, 2'd1,
                  32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0, 4'h0, 32'h0);
`ifdef STORE_MISALIGN_EN
    vecs[2]  = mk(32'h0000_0102, 32'h1122_3344, 3'b010, 4'd2, 1'b0, 2'd2,
                  32'h0000_0100, 4'b1100, 32'h3344_0000, 32'h0000_0104, 4'b0011, 32'h0000_1122);
    vecs[6]  = mk(32'h0000_0003, 32'h0000_1234, 3'b001, 4'd0, 1'b0, 2'd2,
                  32'h0000_0000, 4'b1000, 32'h3400_0000, 32'h0000_0004, 4'b0001, 32'h0000_0012);
    vecs[8]  = mk(32'hFFFF_FFFF, 32'hAABB_CCDD, 3'b010, 4'd1, 1'b0, 2'd2,
                  32'hFFFF_FFFC, 4'b1000, 32'hDD00_0000, 32'h0000_0000, 4'b0111, 32'h00AA_BBCC);
    vecs[10] = mk(32'h0000_0001, 32'h0102_0304, 3'b010, 4'd0, 1'b0, 2'd2,
                  32'h0000_0000, 4'b1110, 32'h0203_0400, 32'h0000_0004, 4'b0001, 32'h0000_0001);
`else
    vecs[2]  = mk_err(32'h0000_0102, 32'h1122_3344, 3'b010);
    vecs[6]  = mk_err(32'h0000_0003, 32'h0000_1234, 3'b001);
    vecs[8]  = mk_err(32'hFFFF_FFFF, 32'hAABB_CCDD, 3'b010);
    vecs[10] = mk_err(32'h0000_0001, 32'h0102_0304, 3'b010);
`endif
    vecs[3]  = mk_err(32'h0000_0100, 32'h1234_5678, 3'b100);
    vecs[4]  = mk_err(32'h0000_0040, 32'h1234_5678, 3'b011);
    vecs[5]  = mk(32'h0000_0002, 32'h0000_CAFE, 3'b001, 4'd1, 1'b0, 2'd1,
                  32'h0000_0000, 4'b1100, 32'hCAFE_0000, 32'h0, 4'h0, 32'h0);
    // upper SB bits are garbage; only the enabled lane is compared
    vecs[7]  = mk(32'h0000_0001, 32'hFFFF_FF5A, 3'b000, 4'd0, 1'b0, 2'd1,
                  32'h0000_0000, 4'b0010, 32'h0000_5A00, 32'h0, 4'h0, 32'h0);
    vecs[9]  = mk(32'h0000_0105, 32'h0000_7788, 3'b001, 4'd0, 1'b0, 2'd1,
                  32'h0000_0104, 4'b0110, 32'h0077_8800, 32'h0, 4'h0, 32'h0);

    // reset state
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'd1);

    // stray ack while idle must do nothing
    i_mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("idle_ack_we", 32'(o_mem_we), 32'd0);
      chk("idle_ack_done", 32'(o_done), 32'd0);
      chk("idle_ack_ready", 32'(o_req_ready), 32'd1);
    end
    i_mem_ack = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // request held valid: not taken during RESP, taken again once idle
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0010;
    i_req_data  = 32'h0;
    i_req_type  = 3'b111;
    @(negedge i_clk);
    chk("b2b_done1", 32'(o_done), 32'd1);
    chk("b2b_ready_resp", 32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    chk("b2b_gap", 32'(o_done), 32'd0);
    chk("b2b_ready_idle", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    chk("b2b_done2", 32'(o_done), 32'd1);
    chk("b2b_err2", 32'(o_err), 32'd1);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("b2b_ready_end", 32'(o_req_ready), 32'd1);

    // reset in the middle of a beat
    i_req_valid = 1'b1;
`ifdef STORE_MISALIGN_EN
    i_req_addr = 32'h0000_0003;
    i_req_type = 3'b001;
    i_req_data = 32'h0000_BEEF;
`else
    i_req_addr = 32'h0000_0100;
    i_req_type = 3'b010;
    i_req_data = 32'h1357_9BDF;
`endif
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("mrst_beat0_we", 32'(o_mem_we), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("mrst_we_now", 32'(o_mem_we), 32'd0);
    chk("mrst_addr_now", o_mem_addr, 32'h0);
    chk("mrst_be_now", 32'(o_mem_be), 32'd0);
    chk("mrst_done_now", 32'(o_done), 32'd0);
    i_mem_ack = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("mrst_no_beat1", 32'(o_mem_we), 32'd0);
      chk("mrst_no_done", 32'(o_done), 32'd0);
      chk("mrst_ready", 32'(o_req_ready), 32'd1);
    end
    i_mem_ack = 1'b0;

    // normal operation after the abandoned request
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store-side counterpart to the core's load-type select logic. It accepts one store request at a time from the execute stage, encoded with the same 3-bit funct3 type field. It drives a word-addressed data memory with byte enables and lane-shifted write data, and holds each beat until the memory acknowledges it. Misaligned stores that cross a word boundary are split into two memory beats.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 is supported
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  high while idle; a request is accepted on a clk edge with req_valid && req_ready && !rst
- req_addr  in  ADDR_W  byte address
- req_data  in  32  store data, right-justified
- req_type  in  3  store type: 000 SB, 001 SH, 010 SW; 011 and 100 are illegal for stores
- mem_we  out  1  write beat valid, held until mem_ack
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  memory accepted the current beat (sampled only while mem_we=1)
- done  out  1  one-cycle pulse when the request retires
- err  out  1  one-cycle pulse with done on an illegal type or (without macro) a misaligned store

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- Lane computation:
  - off = req_addr[1:0]
  - 8-bit base enable = 0001 (SB), 0011 (SH), 1111 (SW), shifted left by off
  - 64-bit data = req_data << (8*off)
  - Beat0 uses the low 4 enable bits, data[31:0], and address {addr[31:2],2'b00}.
  - Beat1 uses the high 4 enable bits, data[63:32], and beat0 address + 4 (wraps modulo 2^ADDR_W).
  - split = high 4 enable bits ≠ 0.
- IDLE, on accept:
  - illegal type → RESP with err=1; no memory write.
  - otherwise → BEAT0, with mem_* loaded from beat0 values.
- BEAT0: mem_we=1, mem_* stable until mem_ack.
  - On ack: if split → BEAT1 (mem_* reloaded with beat1 values); else → RESP.
- BEAT1: mem_we=1, hold until mem_ack, then → RESP.
- RESP: done=1, mem_we=0, then → IDLE.
- req_data, req_addr and req_type are captured at accept; later changes have no effect.
- Unused store bits (SB [31:8], SH [31:16]) are ignored.

## Timing
- All outputs are registered except req_ready, which is (state==IDLE).
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, done 0, err 0.
- Aligned store with immediate ack:
  - accept at edge 0
  - mem_we high in cycle 1
  - done in cycle 2
  - req_ready in cycle 3
- Each beat takes ≥1 cycle; wait states are unbounded.
- Split store with immediate acks: done in cycle 3.
- Illegal type: done+err in cycle 1; mem_we is never asserted.
- A request presented in RESP is not accepted (ready=0). Back-to-back throughput is therefore one store per 3 cycles minimum.
- mem_ack while mem_we=0 is ignored.
- rst asserted mid-operation: all outputs clear immediately, any pending beat is abandoned, and the block returns to IDLE. A beat1 is never issued after reset.

## Configuration
- STORE_MISALIGN_EN defined: crossing stores split into BEAT0/BEAT1 as above.
- STORE_MISALIGN_EN undefined:
  - Any store with split=1 (SH off=3, SW off≠0) goes IDLE→RESP with err=1 and no write.
  - BEAT1 logic is removed.
  - Non-crossing misaligned SB/SH still write normally.

## Structure
- Package store_pkg holds:
  - type constants ST_SB=3'b000, ST_SH=3'b001, ST_SW=3'b010
  - state encodings
  - lane width constant (8)
- Sub-module store_lane_align: combinational; takes off, type and data; produces 8-bit enables, 64-bit data and split.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack immediate → one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; done cycle 2; err 0.
- SB addr 0x203, data 0x000000A5 → addr 0x200, be 1000, wdata 0xA5000000.
- SW addr 0x102, data 0x11223344, macro on, ack delayed 2 cycles per beat → beat0 addr 0x100, be 1100, wdata 0x33440000; beat1 addr 0x104, be 0011, wdata 0x00001122; done after the second ack. With macro off → done+err, mem_we never high.
- req_type 3'b100 → done and err pulse in cycle 1; mem_we stays 0; req_ready returns the next cycle.
- SH addr 0x003 split (macro on), rst raised during BEAT0 → mem_we drops immediately; no beat1 to 0x004 after reset release; req_ready=1.
